// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Start/Done handshake; divide-by-zero resolves in the accepting cycle.
module sequential_divider #(
  parameter int n = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero
);

  localparam int CW = $clog2(n);

  typedef enum logic {
    IDLE,
    DIVIDE
  } state_t;

  state_t state, state_d;

  logic [n-1:0]  qs;
  logic [n-1:0]  breg;
  logic [n-1:0]  pr;
  logic [CW-1:0] cnt;
  logic [n:0]    shifted;
  logic [n:0]    trial;
  logic [n-1:0]  pr_d;
  logic [n-1:0]  qs_d;
  logic          fits;
  logic          last;
  logic          accept;

  // Subtract by adding the inverted divisor with a carry-in of one.
  // A stored partial remainder is always below the divisor, so its
  // top bit is zero and only n bits need to be kept.
  always_comb begin
    shifted = {pr, qs[n-1]};
    trial   = shifted + {1'b1, ~breg} + {{n{1'b0}}, 1'b1};
    fits    = ~trial[n];
    pr_d    = fits ? trial[n-1:0] : shifted[n-1:0];
    qs_d    = {qs[n-2:0], fits};
    last    = (cnt == '0);
    accept  = (state == IDLE) && Start;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (Start && (B != '0)) state_d = DIVIDE;
      DIVIDE:  if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      qs        <= '0;
      breg      <= '0;
      pr        <= '0;
      cnt       <= '0;
      Q         <= '0;
      R         <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        qs   <= A;
        breg <= B;
        pr   <= '0;
        cnt  <= CW'(n - 1);
        if (B == '0) begin
          Q         <= '1;
          R         <= A;
          DivByZero <= 1'b1;
          Done      <= 1'b1;
        end
      end else if (state == DIVIDE) begin
        pr  <= pr_d;
        qs  <= qs_d;
        cnt <= cnt - CW'(1);
        if (last) begin
          Q         <= qs_d;
          R         <= pr_d;
          DivByZero <= 1'b0;
          Done      <= 1'b1;
        end
      end
    end
  end

  assign Busy = (state == DIVIDE);

endmodule
